// File: rtl/sandpile_grid_arbiter.sv
// sandpile_grid_arbiter: shares the single-port grid RAM between the VGA renderer (priority) and the
// simulation engine, with range checking and tagged two-cycle read return.
module sandpile_grid_arbiter #(
   parameter int MAX_SIZE = 32,
   parameter int AW       = $clog2(MAX_SIZE),
   parameter int STALL_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [AW:0]        grid_size,
   input  logic               vga_active,
   input  logic [AW-1:0]      vga_addr_x,
   input  logic [AW-1:0]      vga_addr_y,
   output logic [2:0]         vga_data,
   input  logic               sim_req,
   input  logic               sim_we,
   input  logic [AW-1:0]      sim_addr_x,
   input  logic [AW-1:0]      sim_addr_y,
   input  logic [2:0]         sim_wdata,
   output logic               sim_gnt,
   output logic               sim_rvalid,
   output logic [2:0]         sim_rdata,
   output logic [STALL_W-1:0] sim_stall_cnt,
   output logic               mem_en,
   output logic               mem_we,
   output logic [2*AW-1:0]    mem_addr,
   output logic [2:0]         mem_wdata,
   input  logic [2:0]         mem_rdata
);
   typedef enum logic [1:0] {IDLE, VGA, SIM} grant_e;
   grant_e gsel;
   logic [AW-1:0] ax, ay;
   logic in_range;
   logic tag_vld_q, tag_vld_d, tag_sim_q, tag_sim_d, tag_rd_q, tag_rd_d, tag_in_q, tag_in_d;
   logic [2:0] rd, vga_data_q, vga_data_d, sim_rdata_q, sim_rdata_d;
   logic sim_rvalid_q, sim_rvalid_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   always_comb begin
      gsel = rst ? IDLE : vga_active ? VGA : sim_req ? SIM : IDLE;
      ax = (gsel == SIM) ? sim_addr_x : vga_addr_x;
      ay = (gsel == SIM) ? sim_addr_y : vga_addr_y;
      in_range = ({1'b0, ax} < grid_size) && ({1'b0, ay} < grid_size);
      sim_gnt = gsel == SIM;
      mem_en = (gsel != IDLE) && in_range;
      mem_we = sim_gnt && sim_we && in_range;
      mem_addr = (gsel == IDLE) ? '0 : {ay, ax};
      mem_wdata = sim_gnt ? sim_wdata : '0;
      tag_vld_d = gsel != IDLE;
      tag_sim_d = sim_gnt;
      tag_rd_d = (gsel == VGA) || !sim_we;
      tag_in_d = in_range;
      // Out-of-range reads never enabled the RAM, so mem_rdata is stale and must be masked.
      rd = tag_in_q ? mem_rdata : '0;
      vga_data_d = (tag_vld_q && !tag_sim_q) ? rd : vga_data_q;
      sim_rvalid_d = tag_vld_q && tag_sim_q && tag_rd_q;
      sim_rdata_d = sim_rvalid_d ? rd : sim_rdata_q;
      stall_d = (!sim_req || sim_gnt) ? '0 : (&stall_q) ? stall_q : stall_q + 1'b1;
      vga_data = rst ? '0 : vga_data_q;
      sim_rvalid = rst ? 1'b0 : sim_rvalid_q;
      sim_rdata = rst ? '0 : sim_rdata_q;
      sim_stall_cnt = rst ? '0 : stall_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_vld_q <= 1'b0;
         tag_sim_q <= 1'b0;
         tag_rd_q <= 1'b0;
         tag_in_q <= 1'b0;
         vga_data_q <= '0;
         sim_rvalid_q <= 1'b0;
         sim_rdata_q <= '0;
         stall_q <= '0;
      end else begin
         tag_vld_q <= tag_vld_d;
         tag_sim_q <= tag_sim_d;
         tag_rd_q <= tag_rd_d;
         tag_in_q <= tag_in_d;
         vga_data_q <= vga_data_d;
         sim_rvalid_q <= sim_rvalid_d;
         sim_rdata_q <= sim_rdata_d;
         stall_q <= stall_d;
      end
   end
endmodule
